encoder_scan_sequencer: RTL



---
 rtl/encoder_scan_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/encoder_scan_sequencer.sv
// Time-multiplexed gated pulse counter: scans enabled encoder channels in ascending order
// and reports one count per channel on a valid/ack handshake. Optional ENC_SEQ_OVF_FLAG_EN adds count_ovf.
module encoder_scan_sequencer #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CW         = 8,
    parameter int unsigned GW         = 16,
    parameter int unsigned SETTLE_CYC = 2,
    localparam int unsigned SELW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            OUT_CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] A,
    input  logic            start,
    input  logic            cont,
    input  logic [N_CH-1:0] ch_mask,
    input  logic [GW-1:0]   gate_len,
    output logic            busy,
    output logic [SELW-1:0] sel,
    output logic [CW-1:0]   count_data,
    output logic [SELW-1:0] count_ch,
    output logic            count_valid,
    input  logic            count_ack
`ifdef ENC_SEQ_OVF_FLAG_EN
    ,
    output logic            count_ovf
`endif
);

    localparam int unsigned STW = $clog2(SETTLE_CYC);

    typedef enum logic [2:0] {IDLE, SETTLE, GATE, REPORT, NEXT} state_t;

    state_t            state;
    logic [N_CH-1:0]   mask_q;
    logic [GW-1:0]     gl_q;
    logic [STW-1:0]    settle_cnt;
    logic [GW-1:0]     gate_cnt;
    logic [CW-1:0]     counter;
    logic              sync1, sync2, sync_d;
    logic              rise;
`ifdef ENC_SEQ_OVF_FLAG_EN
    logic              sat;
`endif

    logic [SELW-1:0]   next_ch, low_ch, start_ch;
    logic              next_found;

    // Selected input: 2-flop synchronizer plus one delay stage for rising-edge detection
    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= A[sel];
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign rise = sync2 & ~sync_d;

    // Channel search: next enabled above sel, lowest latched, lowest requested at start
    always_comb begin
        next_ch    = '0;
        next_found = 1'b0;
        low_ch     = '0;
        start_ch   = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (mask_q[i]) low_ch = SELW'(i);
            if (ch_mask[i]) start_ch = SELW'(i);
            if (mask_q[i] && (SELW'(i) > sel)) begin
                next_ch    = SELW'(i);
                next_found = 1'b1;
            end
        end
    end

    // Scan sequencer
    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            mask_q      <= '0;
            gl_q        <= '0;
            settle_cnt  <= '0;
            gate_cnt    <= '0;
            counter     <= '0;
            busy        <= 1'b0;
            sel         <= '0;
            count_data  <= '0;
            count_ch    <= '0;
            count_valid <= 1'b0;
`ifdef ENC_SEQ_OVF_FLAG_EN
            sat         <= 1'b0;
            count_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && (ch_mask != '0)) begin
                        mask_q     <= ch_mask;
                        gl_q       <= gate_len;
                        sel        <= start_ch;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    counter <= '0;
`ifdef ENC_SEQ_OVF_FLAG_EN
                    sat     <= 1'b0;
`endif
                    if (settle_cnt == STW'(SETTLE_CYC - 1)) begin
                        // gate_len of 0 is treated as a single-cycle window
                        gate_cnt <= (gl_q == '0) ? '0 : gl_q - GW'(1);
                        state    <= GATE;
                    end else begin
                        settle_cnt <= settle_cnt + STW'(1);
                    end
                end
                GATE: begin
                    if (rise) begin
                        if (counter != {CW{1'b1}}) begin
                            counter <= counter + CW'(1);
                        end
`ifdef ENC_SEQ_OVF_FLAG_EN
                        else begin
                            sat <= 1'b1;
                        end
`endif
                    end
                    if (gate_cnt == '0) begin
                        state <= REPORT;
                    end else begin
                        gate_cnt <= gate_cnt - GW'(1);
                    end
                end
                REPORT: begin
                    if (!count_valid) begin
                        count_data  <= counter;
                        count_ch    <= sel;
                        count_valid <= 1'b1;
`ifdef ENC_SEQ_OVF_FLAG_EN
                        count_ovf   <= sat;
`endif
                    end else if (count_ack) begin
                        count_valid <= 1'b0;
                        state       <= NEXT;
                    end
                end
                NEXT: begin
                    settle_cnt <= '0;
                    if (next_found) begin
                        sel   <= next_ch;
                        state <= SETTLE;
                    end else if (cont) begin
                        sel   <= low_ch;
                        state <= SETTLE;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
